rz_scan_reader: RTL and testbench

- Downstream consumer of the six-channel RZ (ARINC429) receiver.
- On each frame strobe, sweeps the 32-word RAM of every enabled channel through the rd_arincN / arinc_N_outp ports.
- Delivers every word, tagged with its channel and address, as a valid/ready stream to the FDAU frame assembler.
- Runs on the same clock as the receiver (clk_400kHz).

---
 rtl/rz_scan_reader.sv | 166 ++++++++++++++++
 tb/tb_rz_scan_reader.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rz_scan_reader.sv
// Sweeps the RZ receiver word RAMs of enabled channels on a frame strobe and streams {ch, addr, data} out.
// Latency: first word valid RD_LAT+2 cycles after start; one word per RD_LAT+2 cycles; stalls while out_ready is low.
module rz_scan_reader #(
   parameter int WORDS_PER_CH = 32,
   parameter int RD_LAT       = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic [5:0]  ch_enable,
   output logic        busy,
   output logic        done,
   output logic [4:0]  rd_arinc1,
   output logic [4:0]  rd_arinc2,
   output logic [4:0]  rd_arinc3,
   output logic [4:0]  rd_arinc4,
   output logic [4:0]  rd_arinc5,
   output logic [4:0]  rd_arinc6,
   input  logic [15:0] arinc_1_outp,
   input  logic [15:0] arinc_2_outp,
   input  logic [15:0] arinc_3_outp,
   input  logic [15:0] arinc_4_outp,
   input  logic [15:0] arinc_5_outp,
   input  logic [15:0] arinc_6_outp,
   output logic [15:0] out_data,
   output logic [2:0]  out_ch,
   output logic [4:0]  out_addr,
   output logic        out_valid,
   input  logic        out_ready
);

   localparam int LAT_W = $clog2(RD_LAT + 1);

   typedef enum logic [1:0] {IDLE, READ, PRESENT, FINISH} state_t;

   state_t           state, state_nxt;
   logic [5:0]       mask;
   logic [2:0]       ch_idx;
   logic [4:0]       addr;
   logic [LAT_W-1:0] lat_cnt;

   logic [2:0]       first_idx;
   logic             first_found;
   logic [2:0]       next_idx;
   logic             next_found;
   logic             lat_last;
   logic             addr_last;
   logic [15:0]      ram_q;

   // One address bus feeds all six RAMs; only the active channel's data is used.
   assign rd_arinc1 = addr;
   assign rd_arinc2 = addr;
   assign rd_arinc3 = addr;
   assign rd_arinc4 = addr;
   assign rd_arinc5 = addr;
   assign rd_arinc6 = addr;

   assign lat_last  = (lat_cnt == LAT_W'(RD_LAT));
   assign addr_last = (addr == 5'(WORDS_PER_CH - 1));

   // Descending scans so the lowest qualifying channel wins.
   always_comb begin
      first_idx   = 3'd0;
      first_found = 1'b0;
      next_idx    = 3'd0;
      next_found  = 1'b0;
      for (int i = 5; i >= 0; i--) begin
         if (ch_enable[i]) begin
            first_idx   = 3'(i);
            first_found = 1'b1;
         end
         if (mask[i] && (i > int'(ch_idx))) begin
            next_idx   = 3'(i);
            next_found = 1'b1;
         end
      end
   end

   always_comb begin
      case (ch_idx)
         3'd0:    ram_q = arinc_1_outp;
         3'd1:    ram_q = arinc_2_outp;
         3'd2:    ram_q = arinc_3_outp;
         3'd3:    ram_q = arinc_4_outp;
         3'd4:    ram_q = arinc_5_outp;
         3'd5:    ram_q = arinc_6_outp;
         default: ram_q = 16'h0000;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_nxt = first_found ? READ : FINISH;
         end
         READ: begin
            busy = 1'b1;
            if (lat_last) state_nxt = PRESENT;
         end
         PRESENT: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) state_nxt = (!addr_last || next_found) ? READ : FINISH;
         end
         FINISH: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // addr only moves when heading into READ, so the RAM address holds through FINISH/IDLE.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         mask     <= 6'd0;
         ch_idx   <= 3'd0;
         addr     <= 5'd0;
         lat_cnt  <= '0;
         out_data <= 16'h0000;
         out_ch   <= 3'd0;
         out_addr <= 5'd0;
      end else begin
         case (state)
            IDLE: begin
               lat_cnt <= '0;
               if (start) begin
                  mask   <= ch_enable;
                  ch_idx <= first_idx;
                  addr   <= 5'd0;
               end
            end
            READ: begin
               lat_cnt <= lat_cnt + 1'b1;
               if (lat_last) begin
                  out_data <= ram_q;
                  out_ch   <= ch_idx + 3'd1;
                  out_addr <= addr;
               end
            end
            PRESENT: begin
               lat_cnt <= '0;
               if (out_ready) begin
                  if (!addr_last) begin
                     addr <= addr + 5'd1;
                  end else if (next_found) begin
                     addr   <= 5'd0;
                     ch_idx <= next_idx;
                  end
               end
            end
            default: lat_cnt <= '0;
         endcase
      end
   end

endmodule

// File: tb/tb_rz_scan_reader.sv
// Directed bench for rz_scan_reader: table of sweep scenarios scored against a {ch, addr} RAM model,
// plus a hand-written mid-sweep reset sequence.
module tb_rz_scan_reader;

   logic        clock = 1'b0;
   logic        reset;
   logic        start;
   logic [5:0]  ch_enable;
   logic        busy, done;
   logic [4:0]  rd_arinc1, rd_arinc2, rd_arinc3, rd_arinc4, rd_arinc5, rd_arinc6;
   logic [15:0] arinc_1_outp, arinc_2_outp, arinc_3_outp, arinc_4_outp, arinc_5_outp, arinc_6_outp;
   logic [15:0] out_data;
   logic [2:0]  out_ch;
   logic [4:0]  out_addr;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] salt;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   rz_scan_reader dut (
      .clock(clock), .reset(reset), .start(start), .ch_enable(ch_enable),
      .busy(busy), .done(done),
      .rd_arinc1(rd_arinc1), .rd_arinc2(rd_arinc2), .rd_arinc3(rd_arinc3),
      .rd_arinc4(rd_arinc4), .rd_arinc5(rd_arinc5), .rd_arinc6(rd_arinc6),
      .arinc_1_outp(arinc_1_outp), .arinc_2_outp(arinc_2_outp), .arinc_3_outp(arinc_3_outp),
      .arinc_4_outp(arinc_4_outp), .arinc_5_outp(arinc_5_outp), .arinc_6_outp(arinc_6_outp),
      .out_data(out_data), .out_ch(out_ch), .out_addr(out_addr),
      .out_valid(out_valid), .out_ready(out_ready)
   );

   // Receiver RAM model: two-cycle read latency, word = {ch, addr} scrambled by salt.
   function automatic logic [15:0] pat(input int ch, input logic [4:0] a, input logic [15:0] s);
      return {8'(ch), 3'b000, a} ^ s;
   endfunction

   logic [4:0] rd [6];
   logic [4:0] d1 [6];
   logic [4:0] d2 [6];
   assign rd[0] = rd_arinc1;
   assign rd[1] = rd_arinc2;
   assign rd[2] = rd_arinc3;
   assign rd[3] = rd_arinc4;
   assign rd[4] = rd_arinc5;
   assign rd[5] = rd_arinc6;

   always @(posedge clock) begin
      for (int k = 0; k < 6; k++) begin
         d1[k] <= rd[k];
         d2[k] <= d1[k];
      end
   end

   assign arinc_1_outp = pat(1, d2[0], salt);
   assign arinc_2_outp = pat(2, d2[1], salt);
   assign arinc_3_outp = pat(3, d2[2], salt);
   assign arinc_4_outp = pat(4, d2[3], salt);
   assign arinc_5_outp = pat(5, d2[4], salt);
   assign arinc_6_outp = pat(6, d2[5], salt);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   typedef struct {
      logic [5:0]  mask;
      int          exp_xfers;
      int          stall_ch;
      int          stall_addr;
      int          stall_len;
      int          spur;
      logic [15:0] salt;
   } vec_t;

   task automatic run_vec(input vec_t v);
      int exp_ch[$];
      int exp_addr[$];
      int n = 0, cyc = 1, post = 0;
      int first_valid = -1, done_cnt = 0, done_cyc = -1, last_x = -1, prev_x = -1;
      int gap_err = 0, busy_err = 0, bad_ch = 0, valid_cnt = 0;
      int stall_cnt = 0, stall_first = -1, stall_release = -1;
      logic [15:0] hd;
      logic [2:0]  hc;
      logic [4:0]  ha;

      for (int c = 1; c <= 6; c++)
         if (v.mask[c-1])
            for (int a = 0; a < 32; a++) begin
               exp_ch.push_back(c);
               exp_addr.push_back(a);
            end

      salt      = v.salt;
      out_ready = 1'b1;
      ch_enable = v.mask;
      start     = 1'b1;
      tick();
      forever begin
         start = (cyc == v.spur);
         if (cyc == 10) ch_enable = ~v.mask;
         if (done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = cyc;
            if (busy) busy_err++;
         end else if (v.mask == 6'd0 ? busy : (done_cyc < 0 && !busy)) begin
            busy_err++;
         end
         if (out_valid) begin
            valid_cnt++;
            if (first_valid < 0) first_valid = cyc;
            if (out_ch < 1 || out_ch > 6 || !v.mask[out_ch-1]) bad_ch++;
            if (v.stall_len > 0 && stall_cnt < v.stall_len &&
                out_ch == v.stall_ch && out_addr == v.stall_addr) begin
               if (stall_cnt == 0) begin
                  hd = out_data; hc = out_ch; ha = out_addr;
                  stall_first = cyc;
               end else begin
                  chk("stall_data", out_data, hd);
                  chk("stall_ch", out_ch, hc);
                  chk("stall_addr", out_addr, ha);
               end
               out_ready = 1'b0;
               stall_cnt++;
            end else begin
               out_ready = 1'b1;
               if (stall_first >= 0 && stall_release < 0) stall_release = cyc;
               if (n < exp_ch.size()) begin
                  chk("xfer_ch", out_ch, exp_ch[n]);
                  chk("xfer_addr", out_addr, exp_addr[n]);
                  chk("xfer_data", out_data, pat(exp_ch[n], 5'(exp_addr[n]), v.salt));
               end else begin
                  chk("extra_xfer", n, exp_ch.size());
               end
               if (prev_x >= 0 && v.stall_len == 0 && cyc - prev_x != 4) gap_err++;
               prev_x = cyc;
               last_x = cyc;
               n++;
            end
         end else begin
            out_ready = 1'b1;
         end
         if (done_cyc >= 0) post++;
         if (post > 3) break;
         if (cyc > 3000) begin
            chk("sweep_timeout", cyc, 0);
            break;
         end
         tick();
         cyc++;
      end
      start     = 1'b0;
      out_ready = 1'b1;

      chk("xfer_count", n, v.exp_xfers);
      chk("done_pulses", done_cnt, 1);
      chk("busy_profile", busy_err, 0);
      chk("disabled_ch_seen", bad_ch, 0);
      if (v.exp_xfers == 0) begin
         chk("empty_done_cyc", done_cyc, 1);
         chk("empty_valid_cycles", valid_cnt, 0);
      end else begin
         chk("first_valid_cyc", first_valid, 4);
         chk("done_after_last", done_cyc, last_x + 1);
      end
      if (v.stall_len == 0) begin
         chk("throughput_gaps", gap_err, 0);
      end else begin
         chk("stall_cycles", stall_cnt, v.stall_len);
         chk("stall_release_cyc", stall_release, stall_first + v.stall_len);
      end
   endtask

   vec_t vecs[7];

   initial begin
      //           mask        xfers stall_ch addr len spur salt
      vecs[0] = '{6'b111111, 192, 0, 0, 0,  -1, 16'h0000};
      vecs[1] = '{6'b100100,  64, 0, 0, 0,  -1, 16'h5A5A};
      vecs[2] = '{6'b000000,   0, 0, 0, 0,  -1, 16'h0000};
      vecs[3] = '{6'b111111, 192, 2, 7, 10, -1, 16'hC3A0};
      vecs[4] = '{6'b111111, 192, 0, 0, 0,  20, 16'h0F0F};
      vecs[5] = '{6'b000001,  32, 0, 0, 0,  -1, 16'hFFFF};
      vecs[6] = '{6'b100000,  32, 0, 0, 0,  -1, 16'h1234};

      reset = 1'b1; start = 1'b0; ch_enable = 6'd0; out_ready = 1'b1; salt = 16'h0000;
      repeat (3) tick();
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_data", out_data, 0);
      chk("rst_ch", out_ch, 0);
      chk("rst_addr", out_addr, 0);
      chk("rst_rd_all", {rd_arinc1, rd_arinc2, rd_arinc3, rd_arinc4, rd_arinc5, rd_arinc6}, 0);
      reset = 1'b0;
      repeat (2) tick();

      for (int i = 0; i < 7; i++) begin
         run_vec(vecs[i]);
         repeat (3) tick();
      end

      // Reset in cycle 50 of a full sweep aborts without a done pulse.
      begin
         int done_seen = 0;
         salt = 16'h0000; ch_enable = 6'b111111; start = 1'b1;
         tick();
         start = 1'b0;
         repeat (49) tick();
         chk("pre_reset_busy", busy, 1);
         #2 reset = 1'b1;
         #1;
         chk("async_rst_busy", busy, 0);
         chk("async_rst_valid", out_valid, 0);
         chk("async_rst_done", done, 0);
         repeat (3) begin
            tick();
            if (done) done_seen++;
         end
         chk("rst_hold_data", out_data, 0);
         chk("rst_hold_rd1", rd_arinc1, 0);
         reset = 1'b0;
         repeat (5) begin
            tick();
            if (done || busy) done_seen++;
         end
         chk("no_done_after_abort", done_seen, 0);
         run_vec(vecs[0]);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
